tour_cmd_seq: RTL and testbench

Parametrised successor of the tour-command translator. It walks the solved knight's tour by index and expands each one-hot move into a vertical-leg and a horizontal-leg 16-bit command. It multiplexes these with UART/BLE commands into the command processor and drives the response byte. It also adds tour abort on a new UART command, invalid-move detection, and a configurable tour length.

---
 rtl/tour_cmd_pkg.sv | 54 +++++
 rtl/tour_cmd_seq_if.sv | 23 ++
 rtl/tour_cmd_seq_move_dec.sv | 34 +++
 rtl/tour_cmd_seq.sv | 135 +++++++++++++
 tb/tb_tour_cmd_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
// Offsets are 3-bit two's complement so +2 and -2 both fit.
package tour_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERT,
    S_WAIT_V,
    S_HORZ,
    S_WAIT_H
  } state_e;

  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_FANF = 4'h3;

  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_E = 8'hBF;

  localparam logic [7:0] RESP_DONE_DEF = 8'hA5;
  localparam logic [7:0] RESP_BUSY_DEF = 8'h5A;

  localparam logic [2:0] D_P1 = 3'b001;
  localparam logic [2:0] D_P2 = 3'b010;
  localparam logic [2:0] D_M1 = 3'b111;
  localparam logic [2:0] D_M2 = 3'b110;

  typedef struct packed {
    logic [2:0] dx;
    logic [2:0] dy;
  } off_t;

  function automatic off_t move_off(
    input logic [7:0] mv
  );
    off_t o;
    o = '0;
    case (mv)
      8'h01: begin o.dx = D_P1; o.dy = D_P2; end
      8'h02: begin o.dx = D_M1; o.dy = D_P2; end
      8'h04: begin o.dx = D_M2; o.dy = D_P1; end
      8'h08: begin o.dx = D_M2; o.dy = D_M1; end
      8'h10: begin o.dx = D_M1; o.dy = D_M2; end
      8'h20: begin o.dx = D_P1; o.dy = D_M2; end
      8'h40: begin o.dx = D_P2; o.dy = D_M1; end
      8'h80: begin o.dx = D_P2; o.dy = D_P1; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command bus between UART wrapper, tour sequencer and command processor.
// master = sequencer side, slave = its environment.
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART,
    input  clr_cmd_rdy, send_resp,
    output cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART,
    output clr_cmd_rdy, send_resp,
    input  cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd_seq_move_dec.sv
// One-hot knight move to vertical/horizontal leg commands.
// valid is low for zero or multi-hot moves.
module tour_move_dec
  import tour_cmd_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        valid
);

  off_t       off;
  logic [2:0] mag_x;
  logic [2:0] mag_y;
  logic       pos_x;
  logic       pos_y;

  always_comb begin
    off   = move_off(move);
    valid = (move != 8'h00) &&
            ((move & (move - 8'h01)) == 8'h00);
    mag_x = off.dx[2] ? (~off.dx + 3'd1) : off.dx;
    mag_y = off.dy[2] ? (~off.dy + 3'd1) : off.dy;
    pos_x = !off.dx[2] && (off.dx != 3'd0);
    pos_y = !off.dy[2] && (off.dy != 3'd0);
    vert_cmd = {OP_MOVE,
                pos_y ? HD_N : HD_S,
                1'b0, mag_y};
    horz_cmd = {OP_FANF,
                pos_x ? HD_E : HD_W,
                1'b0, mag_x};
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Walks the solved tour, emits two legs per move and muxes
// them with UART commands toward the command processor.
module tour_cmd_seq
  import tour_cmd_pkg::*;
#(
  parameter int         NUM_MOVES = 24,
  parameter int         IDX_W     = $clog2(NUM_MOVES),
  parameter bit         ABORT_EN  = 1'b1,
  parameter logic [7:0] RESP_DONE = RESP_DONE_DEF,
  parameter logic [7:0] RESP_BUSY = RESP_BUSY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  tour_cmd_seq_if.master    bus,
  input  logic              start_tour,
  input  logic [7:0]        move,
  output logic [IDX_W-1:0]  mv_indx,
  output logic              tour_busy,
  output logic              abort
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_MOVES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       move_r_q, move_r_d;
  logic             abort_q, abort_d;
  logic             uart_rdy_q, uart_rdy_d;

  logic [7:0]  dec_in;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        dec_valid;
  logic        uart_rise;
  logic        last;

  // LOAD validates the live move; later states use the capture
  assign dec_in = (state_q == S_LOAD) ? move : move_r_q;

  tour_move_dec u_dec (
    .move     (dec_in),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .valid    (dec_valid)
  );

  assign uart_rise = bus.cmd_rdy_UART & ~uart_rdy_q;
  assign last      = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      move_r_q   <= '0;
      abort_q    <= 1'b0;
      uart_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      move_r_q   <= move_r_d;
      abort_q    <= abort_d;
      uart_rdy_q <= uart_rdy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    move_r_d    = move_r_q;
    abort_d     = 1'b0;
    uart_rdy_d  = bus.cmd_rdy_UART;
    bus.cmd     = vert_cmd;
    bus.cmd_rdy = 1'b0;
    bus.resp    = RESP_BUSY;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd     = bus.cmd_UART;
        bus.cmd_rdy = bus.cmd_rdy_UART;
        bus.resp    = RESP_DONE;
        if (start_tour) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        move_r_d = move;
        if (dec_valid) begin
          state_d = S_VERT;
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
          abort_d = 1'b1;
        end
      end
      S_VERT: begin
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_d = S_WAIT_V;
      end
      S_WAIT_V: begin
        if (bus.send_resp) state_d = S_HORZ;
      end
      S_HORZ: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_d = S_WAIT_H;
      end
      S_WAIT_H: begin
        bus.cmd = horz_cmd;
        if (last) bus.resp = RESP_DONE;
        if (bus.send_resp) begin
          if (last) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            state_d = S_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a fresh UART command overrides anything the tour wanted
    if (ABORT_EN && (state_q != S_IDLE) && uart_rise) begin
      state_d = S_IDLE;
      idx_d   = '0;
      abort_d = 1'b1;
    end
  end

  assign mv_indx   = idx_q;
  assign tour_busy = (state_q != S_IDLE);
  assign abort     = abort_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: one abort-enabled and one abort-disabled
// instance, 3-move tours, legs predicted from knight offsets.
module tb_tour_cmd_seq;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] cmd_uart;
  logic        rdy_uart;
  logic        clr;
  logic        send;
  logic [7:0]  tour [4];

  logic [1:0] idx_a, idx_n;
  logic [7:0] move_a, move_n;
  logic       busy_a, busy_n;
  logic       abort_a, abort_n;

  int nchk;
  int nerr;

  int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  tour_cmd_seq_if if_a ();
  tour_cmd_seq_if if_n ();

  assign if_a.cmd_UART     = cmd_uart;
  assign if_a.cmd_rdy_UART = rdy_uart;
  assign if_a.clr_cmd_rdy  = clr;
  assign if_a.send_resp    = send;
  assign if_n.cmd_UART     = cmd_uart;
  assign if_n.cmd_rdy_UART = rdy_uart;
  assign if_n.clr_cmd_rdy  = clr;
  assign if_n.send_resp    = send;

  assign move_a = tour[idx_a];
  assign move_n = tour[idx_n];

  tour_cmd_seq #(.NUM_MOVES(N), .ABORT_EN(1'b1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (if_a),
    .start_tour (start),
    .move       (move_a),
    .mv_indx    (idx_a),
    .tour_busy  (busy_a),
    .abort      (abort_a)
  );

  tour_cmd_seq #(.NUM_MOVES(N), .ABORT_EN(1'b0)) dut_n (
    .clk        (clk),
    .rst        (rst),
    .bus        (if_n),
    .start_tour (start),
    .move       (move_n),
    .mv_indx    (idx_n),
    .tour_busy  (busy_n),
    .abort      (abort_n)
  );

  function automatic logic [15:0] exp_leg(
    input logic [7:0] mv,
    input bit         horiz
  );
    int k;
    int d;
    k = 0;
    for (int b = 0; b < 8; b++) if (mv[b]) k = b;
    d = horiz ? dxs[k] : dys[k];
    if (horiz)
      return {4'h3, (d > 0) ? 8'hBF : 8'h3F,
              4'(d < 0 ? -d : d)};
    return {4'h2, (d > 0) ? 8'h00 : 8'h7F,
            4'(d < 0 ? -d : d)};
  endfunction

  function automatic logic [7:0] rand_move();
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; clr = 1'b0;
    send = 1'b0; rdy_uart = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clr = 1'b0;
    send = 1'b0; rdy_uart = 1'b0; cmd_uart = '0;
    tick(); tick();
    rst = 1'b0;
    nchk++; if (busy_a !== 1'b0) begin nerr++;
      $display("FAIL reset busy: got %b want 0", busy_a); end
    nchk++; if (abort_a !== 1'b0) begin nerr++;
      $display("FAIL reset abort: got %b want 0", abort_a); end
    nchk++; if (idx_a !== 2'd0) begin nerr++;
      $display("FAIL reset idx: got %0d want 0", idx_a); end
    nchk++; if (if_a.resp !== 8'hA5) begin nerr++;
      $display("FAIL reset resp: got %h want a5", if_a.resp); end
    cmd_uart = 16'($urandom);
    rdy_uart = 1'b1;
    #1;
    nchk++; if (if_a.cmd !== cmd_uart) begin nerr++;
      $display("FAIL idle cmd: got %h want %h", if_a.cmd, cmd_uart); end
    nchk++; if (if_a.cmd_rdy !== 1'b1) begin nerr++;
      $display("FAIL idle rdy: got %b want 1", if_a.cmd_rdy); end
    rdy_uart = 1'b0;
    #1;
    nchk++; if (if_a.cmd_rdy !== 1'b0) begin nerr++;
      $display("FAIL idle rdy low: got %b want 0", if_a.cmd_rdy); end
    tick();
  endtask

  task automatic run_tour(input string nm);
    logic [15:0] ev, eh;
    logic [7:0]  er;
    start = 1'b1; tick(); start = 1'b0;
    nchk++; if (busy_a !== 1'b1 || if_a.cmd_rdy !== 1'b0) begin nerr++;
      $display("FAIL %s load: busy %b rdy %b want 1 0",
               nm, busy_a, if_a.cmd_rdy); end
    for (int i = 0; i < N; i++) begin
      ev = exp_leg(tour[i], 1'b0);
      eh = exp_leg(tour[i], 1'b1);
      tick();
      nchk++; if (if_a.cmd_rdy !== 1'b1 || if_a.cmd !== ev) begin nerr++;
        $display("FAIL %s vert %0d: rdy %b cmd %h want 1 %h",
                 nm, i, if_a.cmd_rdy, if_a.cmd, ev); end
      nchk++; if (idx_a !== 2'(i)) begin nerr++;
        $display("FAIL %s idx: got %0d want %0d", nm, idx_a, i); end
      clr = 1'b1; tick(); clr = 1'b0;
      nchk++; if (if_a.cmd_rdy !== 1'b0) begin nerr++;
        $display("FAIL %s wait_v rdy: got %b want 0", nm, if_a.cmd_rdy); end
      repeat ($urandom_range(0, 2)) tick();
      send = 1'b1; #1;
      nchk++; if (if_a.resp !== 8'h5A) begin nerr++;
        $display("FAIL %s resp v: got %h want 5a", nm, if_a.resp); end
      tick(); send = 1'b0;
      nchk++; if (if_a.cmd_rdy !== 1'b1 || if_a.cmd !== eh) begin nerr++;
        $display("FAIL %s horz %0d: rdy %b cmd %h want 1 %h",
                 nm, i, if_a.cmd_rdy, if_a.cmd, eh); end
      clr = 1'b1; tick(); clr = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      send = 1'b1; #1;
      er = (i == N - 1) ? 8'hA5 : 8'h5A;
      nchk++; if (if_a.resp !== er) begin nerr++;
        $display("FAIL %s resp h %0d: got %h want %h", nm, i, if_a.resp, er); end
      tick(); send = 1'b0;
      if (i == N - 1) begin
        nchk++; if (busy_a !== 1'b0 || idx_a !== 2'd0) begin nerr++;
          $display("FAIL %s end: busy %b idx %0d want 0 0",
                   nm, busy_a, idx_a); end
      end else begin
        nchk++; if (busy_a !== 1'b1 || idx_a !== 2'(i + 1)) begin nerr++;
          $display("FAIL %s next: busy %b idx %0d want 1 %0d",
                   nm, busy_a, idx_a, i + 1); end
      end
    end
  endtask

  task automatic test_fixed_moves();
    do_reset();
    tour[0] = 8'h01; tour[1] = 8'h10; tour[2] = 8'h80;
    run_tour("fixed");
  endtask

  task automatic test_random_tours();
    for (int t = 0; t < 5; t++) begin
      do_reset();
      for (int j = 0; j < N; j++) tour[j] = rand_move();
      run_tour("random");
    end
  endtask

  task automatic test_abort();
    logic [15:0] eh;
    do_reset();
    for (int j = 0; j < N; j++) tour[j] = rand_move();
    eh = exp_leg(tour[0], 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    cmd_uart = 16'($urandom);
    rdy_uart = 1'b1;
    tick();
    nchk++; if (abort_a !== 1'b1 || busy_a !== 1'b0) begin nerr++;
      $display("FAIL abort_v: abort %b busy %b want 1 0", abort_a, busy_a); end
    nchk++; if (if_a.cmd !== cmd_uart || if_a.cmd_rdy !== 1'b1) begin nerr++;
      $display("FAIL abort_v pass: cmd %h rdy %b want %h 1",
               if_a.cmd, if_a.cmd_rdy, cmd_uart); end
    nchk++; if (idx_a !== 2'd0) begin nerr++;
      $display("FAIL abort_v idx: got %0d want 0", idx_a); end
    nchk++; if (abort_n !== 1'b0 || busy_n !== 1'b1 || if_n.cmd_rdy !== 1'b0) begin
      nerr++;
      $display("FAIL noabort_v: abort %b busy %b rdy %b want 0 1 0",
               abort_n, busy_n, if_n.cmd_rdy); end
    rdy_uart = 1'b0;
    tick();
    nchk++; if (abort_a !== 1'b0) begin nerr++;
      $display("FAIL abort pulse width: got %b want 0", abort_a); end
    send = 1'b1; tick(); send = 1'b0;
    nchk++; if (if_n.cmd_rdy !== 1'b1 || if_n.cmd !== eh) begin nerr++;
      $display("FAIL noabort horz: rdy %b cmd %h want 1 %h",
               if_n.cmd_rdy, if_n.cmd, eh); end
    nchk++; if (busy_a !== 1'b0) begin nerr++;
      $display("FAIL abort stays idle: busy %b want 0", busy_a); end
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    send = 1'b1; tick(); send = 1'b0;
    clr = 1'b1; rdy_uart = 1'b1; cmd_uart = 16'($urandom);
    tick(); clr = 1'b0;
    nchk++; if (abort_a !== 1'b1 || busy_a !== 1'b0) begin nerr++;
      $display("FAIL abort_h: abort %b busy %b want 1 0", abort_a, busy_a); end
    nchk++; if (abort_n !== 1'b0 || busy_n !== 1'b1) begin nerr++;
      $display("FAIL noabort_h: abort %b busy %b want 0 1", abort_n, busy_n); end
    rdy_uart = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    logic [15:0] ev;
    do_reset();
    for (int j = 0; j < N; j++) tour[j] = rand_move();
    ev = exp_leg(tour[0], 1'b0);
    tick();
    start = 1'b1; rdy_uart = 1'b1; cmd_uart = 16'($urandom);
    tick(); start = 1'b0;
    nchk++; if (busy_a !== 1'b1 || abort_a !== 1'b0) begin nerr++;
      $display("FAIL same_cycle load: busy %b abort %b want 1 0",
               busy_a, abort_a); end
    tick();
    nchk++; if (abort_a !== 1'b0 || if_a.cmd_rdy !== 1'b1 || if_a.cmd !== ev) begin
      nerr++;
      $display("FAIL same_cycle vert: abort %b rdy %b cmd %h want 0 1 %h",
               abort_a, if_a.cmd_rdy, if_a.cmd, ev); end
    rdy_uart = 1'b0;
  endtask

  task automatic test_invalid();
    logic [7:0] bad;
    int a, b;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      a = $urandom_range(0, 7);
      b = (a + $urandom_range(1, 7)) % 8;
      bad = (k == 0) ? 8'h03 : (k == 1) ? 8'h00 :
            8'((1 << a) | (1 << b));
      tour[0] = bad; tour[1] = 8'h01; tour[2] = 8'h01;
      start = 1'b1; tick(); start = 1'b0;
      nchk++; if (if_a.cmd_rdy !== 1'b0 || busy_a !== 1'b1) begin nerr++;
        $display("FAIL invalid %h load: rdy %b busy %b want 0 1",
                 bad, if_a.cmd_rdy, busy_a); end
      tick();
      nchk++; if (abort_a !== 1'b1 || busy_a !== 1'b0 || if_a.cmd_rdy !== 1'b0) begin
        nerr++;
        $display("FAIL invalid %h: abort %b busy %b rdy %b want 1 0 0",
                 bad, abort_a, busy_a, if_a.cmd_rdy); end
      tick();
      nchk++; if (abort_a !== 1'b0 || busy_a !== 1'b0) begin nerr++;
        $display("FAIL invalid %h after: abort %b busy %b want 0 0",
                 bad, abort_a, busy_a); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tour[0] = 8'h04; tour[1] = 8'h20; tour[2] = 8'h40;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    send = 1'b1; tick(); send = 1'b0;
    nchk++; if (if_a.resp !== 8'h5A || if_a.cmd !== 16'h33F2) begin nerr++;
      $display("FAIL mid horz: resp %h cmd %h want 5a 33f2",
               if_a.resp, if_a.cmd); end
    cmd_uart = 16'($urandom);
    rst = 1'b1; tick(); rst = 1'b0;
    nchk++; if (busy_a !== 1'b0 || idx_a !== 2'd0 || abort_a !== 1'b0) begin
      nerr++;
      $display("FAIL mid reset: busy %b idx %0d abort %b want 0 0 0",
               busy_a, idx_a, abort_a); end
    nchk++; if (if_a.resp !== 8'hA5 || if_a.cmd !== cmd_uart || if_a.cmd_rdy !== 1'b0)
    begin
      nerr++;
      $display("FAIL mid reset out: resp %h cmd %h rdy %b want a5 %h 0",
               if_a.resp, if_a.cmd, if_a.cmd_rdy, cmd_uart); end
  endtask

  task automatic test_start_busy();
    logic [15:0] eh;
    do_reset();
    for (int j = 0; j < N; j++) tour[j] = rand_move();
    eh = exp_leg(tour[0], 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    nchk++; if (busy_a !== 1'b1 || if_a.cmd_rdy !== 1'b0 || idx_a !== 2'd0) begin
      nerr++;
      $display("FAIL start busy: busy %b rdy %b idx %0d want 1 0 0",
               busy_a, if_a.cmd_rdy, idx_a); end
    send = 1'b1; tick(); send = 1'b0;
    nchk++; if (if_a.cmd_rdy !== 1'b1 || if_a.cmd !== eh) begin nerr++;
      $display("FAIL start busy horz: rdy %b cmd %h want 1 %h",
               if_a.cmd_rdy, if_a.cmd, eh); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end

  initial begin
    nchk = 0;
    nerr = 0;
    test_reset();
    test_fixed_moves();
    test_random_tours();
    test_abort();
    test_same_cycle();
    test_invalid();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
